// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window controller.
// Holds the default frame geometry, the controller state encoding
// and the signed pixel type used throughout the datapath.
package conv_pkg;

    localparam int IMAGE_WIDTH  = 28;
    localparam int KERNEL_WIDTH = 5;
    localparam int DATA_W       = 17;
    // Depth of each line-buffer shift chain between window rows
    localparam int D            = IMAGE_WIDTH - KERNEL_WIDTH;
    localparam int POS_W        = $clog2(IMAGE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/pos_counter.sv
// Row/column position counter for a square WIDTH x WIDTH frame.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   clear          return to (0,0)
//   inc            advance one pixel in raster order (col first)
//   row, col       current position
//   last           position is the final pixel of the frame
//   in_window      a KxK window ending at this position lies inside the image
module pos_counter
    import conv_pkg::*;
#(
    parameter int WIDTH = IMAGE_WIDTH,
    parameter int K     = KERNEL_WIDTH,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] row,
    output logic [PW-1:0] col,
    output logic          last,
    output logic          in_window
);

    localparam logic [PW-1:0] MAX_POS = PW'(WIDTH - 1);
    localparam logic [PW-1:0] KM1     = PW'(K - 1);

    logic [PW-1:0] row_reg;
    logic [PW-1:0] col_reg;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (inc) begin
            if (col_reg == MAX_POS) begin
                col_reg <= '0;
                // Row wraps after the final pixel so the next frame starts at (0,0)
                row_reg <= (row_reg == MAX_POS) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign row       = row_reg;
    assign col       = col_reg;
    assign last      = (row_reg == MAX_POS) && (col_reg == MAX_POS);
    assign in_window = (row_reg >= KM1) && (col_reg >= KM1);

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences one IMAGE_WIDTH x IMAGE_WIDTH frame of signed pixels into the
// line-buffer/window datapath and flags cycles where the KxK window lies
// fully inside the image.
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   start                 begins a frame when idle
//   in_valid/in_data      upstream pixel stream
//   in_ready              a pixel is accepted this cycle when in_valid is high
//   shift_en/shift_data   advance the datapath by one pixel (1 cycle after accept)
//   win_valid             complete in-image window present (2 cycles after accept)
//   out_row/out_col       output-map position of that window
//   busy                  frame in progress
//   frame_done            pulse with the final win_valid of the frame
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = conv_pkg::IMAGE_WIDTH,
    parameter int KERNEL_WIDTH = conv_pkg::KERNEL_WIDTH,
    parameter int DATA_W       = conv_pkg::DATA_W,
    parameter int POS_W        = $clog2(IMAGE_WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              shift_en,
    output logic [DATA_W-1:0] shift_data,
    output logic              win_valid,
    output logic [POS_W-1:0]  out_row,
    output logic [POS_W-1:0]  out_col,
    output logic              busy,
    output logic              frame_done
);

    import conv_pkg::*;

    localparam logic [POS_W-1:0] KM1 = POS_W'(KERNEL_WIDTH - 1);

    state_t state_reg, state_next;
    logic   drain_cnt_reg, drain_cnt_next;

    logic             accept;
    logic             pix_last;
    logic             pix_in_window;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;

    // Stage 1: aligned with shift_en
    logic              shift_en_reg;
    logic [DATA_W-1:0] shift_data_reg;
    logic              s1_win_reg;
    logic              s1_last_reg;
    logic [POS_W-1:0]  s1_row_reg;
    logic [POS_W-1:0]  s1_col_reg;

    // Stage 2: aligned with win_valid, by which time the window registers
    // have absorbed the pixel that completes the window
    logic              win_valid_reg;
    logic              frame_done_reg;
    logic [POS_W-1:0]  out_row_reg;
    logic [POS_W-1:0]  out_col_reg;

    assign in_ready = (state_reg == RUN);
    assign busy     = (state_reg != IDLE);
    assign accept   = in_valid && in_ready;

    pos_counter #(
        .WIDTH (IMAGE_WIDTH),
        .K     (KERNEL_WIDTH),
        .PW    (POS_W)
    ) u_pos (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     ((state_reg == IDLE) && start),
        .inc       (accept),
        .row       (row),
        .col       (col),
        .last      (pix_last),
        .in_window (pix_in_window)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && pix_last) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 1'b0;
                end
            end
            DRAIN: begin
                // Two drain cycles let the final pixel reach win_valid
                if (drain_cnt_reg) begin
                    state_next = IDLE;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_en_reg   <= 1'b0;
            shift_data_reg <= '0;
            s1_win_reg     <= 1'b0;
            s1_last_reg    <= 1'b0;
            s1_row_reg     <= '0;
            s1_col_reg     <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            out_row_reg    <= '0;
            out_col_reg    <= '0;
        end else begin
            shift_en_reg <= accept;
            s1_win_reg   <= accept && pix_in_window;
            s1_last_reg  <= accept && pix_last;
            if (accept) begin
                shift_data_reg <= in_data;
                s1_row_reg     <= row - KM1;
                s1_col_reg     <= col - KM1;
            end
            win_valid_reg  <= s1_win_reg;
            frame_done_reg <= s1_last_reg;
            if (s1_win_reg) begin
                out_row_reg <= s1_row_reg;
                out_col_reg <= s1_col_reg;
            end
        end
    end

    assign shift_en   = shift_en_reg;
    assign shift_data = shift_data_reg;
    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;
    assign out_row    = out_row_reg;
    assign out_col    = out_col_reg;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: the driver pushes expected shift and
// window events (with the cycle they are due) as pixels are accepted; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_conv_window_ctrl;

    localparam int W    = 28;
    localparam int K    = 5;
    localparam int DW   = 17;
    localparam int PW   = $clog2(W);
    localparam int NPIX = W * W;
    localparam int NWIN = (W - K + 1) * (W - K + 1);
    localparam int SW   = 8;
    localparam int SK   = 3;
    localparam int SPW  = $clog2(SW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic          reset_n, start, in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready, shift_en, win_valid, busy, frame_done;
    logic [DW-1:0] shift_data;
    logic [PW-1:0] out_row, out_col;

    // Small-geometry instance
    logic           s_reset_n, s_start, s_in_valid;
    logic [DW-1:0]  s_in_data;
    logic           s_in_ready, s_shift_en, s_win_valid, s_busy, s_frame_done;
    logic [DW-1:0]  s_shift_data;
    logic [SPW-1:0] s_out_row, s_out_col;

    conv_window_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .win_valid  (win_valid),
        .out_row    (out_row),
        .out_col    (out_col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    conv_window_ctrl #(
        .IMAGE_WIDTH  (SW),
        .KERNEL_WIDTH (SK),
        .DATA_W       (DW)
    ) dut_small (
        .clk        (clk),
        .reset_n    (s_reset_n),
        .start      (s_start),
        .in_valid   (s_in_valid),
        .in_data    (s_in_data),
        .in_ready   (s_in_ready),
        .shift_en   (s_shift_en),
        .shift_data (s_shift_data),
        .win_valid  (s_win_valid),
        .out_row    (s_out_row),
        .out_col    (s_out_col),
        .busy       (s_busy),
        .frame_done (s_frame_done)
    );

    typedef struct {
        int due;
        int data;
    } shift_exp_t;

    typedef struct {
        int due;
        int row;
        int col;
        int done;
    } win_exp_t;

    shift_exp_t sq[$];
    win_exp_t   wq[$];

    int errors  = 0;
    int checks  = 0;
    int n_shift = 0;
    int n_win   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitor: compare every presented shift/window against the scoreboard
    always @(negedge clk) begin
        shift_exp_t se;
        win_exp_t   we;
        while (sq.size() > 0 && sq[0].due < cyc) begin
            check("shift_missing", cyc, sq[0].due);
            void'(sq.pop_front());
        end
        while (wq.size() > 0 && wq[0].due < cyc) begin
            check("win_missing", cyc, wq[0].due);
            void'(wq.pop_front());
        end
        if (shift_en) begin
            n_shift++;
            if (sq.size() == 0) begin
                check("shift_unexpected", shift_en, 0);
            end else begin
                se = sq.pop_front();
                check("shift_data", $signed(shift_data), se.data);
                check("shift_cycle", cyc, se.due);
            end
        end
        if (win_valid) begin
            n_win++;
            if (wq.size() == 0) begin
                check("win_unexpected", win_valid, 0);
            end else begin
                we = wq.pop_front();
                check("win_row", out_row, we.row);
                check("win_col", out_col, we.col);
                check("win_done", frame_done, we.done);
                check("win_cycle", cyc, we.due);
            end
        end else if (frame_done) begin
            check("frame_done_alone", frame_done, 0);
        end
    end

    // Reference: pixel n of a frame sits at (n / W, n % W); a window ends there
    // when both coordinates are at least K-1.
    task automatic push_expect(input int idx, input int value);
        int r, c;
        shift_exp_t se;
        win_exp_t   we;
        r = idx / W;
        c = idx % W;
        se.due  = cyc + 1;
        se.data = value;
        sq.push_back(se);
        if (r >= K - 1 && c >= K - 1) begin
            we.due  = cyc + 2;
            we.row  = r - (K - 1);
            we.col  = c - (K - 1);
            we.done = (idx == NPIX - 1) ? 1 : 0;
            wq.push_back(we);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge where busy
    // should have just fallen (the first IDLE cycle), or right after a reset.
    task automatic run_frame(input int base, input int gap_pct,
                             input int start_at, input int reset_at);
        int idx, guard, sh0, wn0;
        sh0 = n_shift;
        wn0 = n_win;
        idx = 0;
        guard = 0;
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", in_ready, 1);
        while (idx < NPIX && guard < 20000) begin
            guard++;
            if (reset_at >= 0 && idx == reset_at) begin
                reset_n  = 1'b0;
                in_valid = 1'b1;
                in_data  = DW'(base + idx);
                // Anything not yet presented is dropped by the reset
                while (sq.size() > 0 && sq[sq.size()-1].due > cyc) void'(sq.pop_back());
                while (wq.size() > 0 && wq[wq.size()-1].due > cyc) void'(wq.pop_back());
                @(negedge clk);
                reset_n  = 1'b1;
                in_valid = 1'b0;
                check("rst_busy", busy, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_shift_en", shift_en, 0);
                check("rst_win_valid", win_valid, 0);
                return;
            end
            in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
            in_data  = DW'(base + idx);
            start    = (idx == start_at);
            if (in_valid && in_ready) begin
                push_expect(idx, base + idx);
                idx++;
            end
            @(negedge clk);
        end
        check("frame_accepted", idx, NPIX);
        in_valid = 1'b0;
        start    = 1'b0;
        check("drain_in_ready", in_ready, 0);
        check("drain_busy1", busy, 1);
        @(negedge clk);
        check("drain_busy2", busy, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("frame_shift_count", n_shift - sh0, NPIX);
        check("frame_win_count", n_win - wn0, NWIN);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under %0d", cyc, 200000);
        $fatal(1);
    end

    initial begin
        int s_idx, s_sh, s_wins, s_first, s_acc18, s_lr, s_lc, s_dn;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        s_reset_n = 1'b0; s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_shift_en", shift_en, 0);
        check("reset_shift_data", shift_data, 0);
        check("reset_win_valid", win_valid, 0);
        check("reset_out_row", out_row, 0);
        check("reset_out_col", out_col, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(0, 0, -1, -1);        // gapless, value = index
        run_frame(-5000, 30, -1, -1);   // back-to-back, random gaps, negative data
        run_frame(1000, 10, 300, -1);   // stray start during RUN
        run_frame(2000, 0, -1, 400);    // reset after pixel 400
        @(negedge clk);
        run_frame(3000, 20, -1, -1);    // full frame after the reset

        repeat (3) @(negedge clk);
        check("shift_queue_left", sq.size(), 0);
        check("win_queue_left", wq.size(), 0);

        // Small geometry: 8x8 image, 3x3 kernel
        s_reset_n = 1'b1;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_idx = 0; s_sh = 0; s_wins = 0; s_first = -1; s_acc18 = -1;
        s_lr = -1; s_lc = -1; s_dn = 0;
        for (int i = 0; i < 100; i++) begin
            if (s_shift_en) begin
                check("small_shift_data", $signed(s_shift_data), s_sh);
                s_sh++;
            end
            if (s_win_valid) begin
                s_wins++;
                if (s_first < 0) begin
                    s_first = cyc;
                    check("small_first_row", s_out_row, 0);
                    check("small_first_col", s_out_col, 0);
                end
            end
            if (s_frame_done) begin
                s_dn++;
                s_lr = int'(s_out_row);
                s_lc = int'(s_out_col);
            end
            s_in_valid = (s_idx < SW * SW);
            s_in_data  = DW'(s_idx);
            if (s_in_valid && s_in_ready) begin
                if (s_idx == 18) s_acc18 = cyc;
                s_idx++;
            end
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        check("small_accepted", s_idx, SW * SW);
        check("small_shift_count", s_sh, SW * SW);
        check("small_win_count", s_wins, (SW - SK + 1) * (SW - SK + 1));
        check("small_first_latency", s_first, s_acc18 + 2);
        check("small_done_count", s_dn, 1);
        check("small_last_row", s_lr, SW - SK);
        check("small_last_col", s_lc, SW - SK);
        check("small_busy_end", s_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
